// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
// The register window is four words at BASE_ADDR:
//   TXDATA: push a byte. STATUS: flags and count. BAUDDIV: clocks per bit. CTRL: enables.
// Reads are combinational and have no side effects.
module io_uart_tx #(
    parameter logic [7:0]  BASE_ADDR   = 8'h40,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    output logic        uart_txd,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Bus decode
    logic       win_hit;
    logic       wr_any;
    logic       wr_txdata;
    logic       wr_status;
    logic       wr_baud;
    logic       wr_ctrl;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic [7:0]    count8;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_ok;
    logic          pop;

    // Software-visible registers
    logic          overflow_reg;
    logic [15:0]   baud_reg;
    logic          tx_en_reg;
    logic          irq_en_reg;

    // Transmit FSM and datapath
    state_t        state_reg;
    state_t        state_next;
    logic [15:0]   div_reg;
    logic [15:0]   div_next;
    logic [15:0]   clk_cnt_reg;
    logic [15:0]   clk_cnt_next;
    logic [2:0]    bit_cnt_reg;
    logic [2:0]    bit_cnt_next;
    logic [7:0]    sh_reg;
    logic [7:0]    sh_next;
    logic          txd_reg;
    logic          txd_next;
    logic [15:0]   eff_div;
    logic          bit_done;

    // Only the low data bits and word-aligned addresses are meaningful.
    logic          unused_bits;
    assign unused_bits = ^{io_addr[1:0], io_data_write[31:16]};

    assign win_hit   = (io_addr[7:4] == BASE_ADDR[7:4]);
    assign wr_any    = io_en & io_we & win_hit;
    assign wr_txdata = wr_any & (io_addr[3:2] == 2'd0);
    assign wr_status = wr_any & (io_addr[3:2] == 2'd1);
    assign wr_baud   = wr_any & (io_addr[3:2] == 2'd2);
    assign wr_ctrl   = wr_any & (io_addr[3:2] == 2'd3);

    assign fifo_full  = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign count8     = 8'(count_reg);

    // A full FIFO still accepts a push when the FSM drains a slot at the same edge.
    assign push_ok = wr_txdata & (~fifo_full | pop);

    // A zero divisor would stall the bit timer, so it runs as one clock per bit.
    assign eff_div  = (baud_reg == 16'd0) ? 16'd1 : baud_reg;
    assign bit_done = (clk_cnt_reg == 16'd0);

    // FIFO storage: contents are not reset, the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= io_data_write[7:0];
        end
    end

    // State register: FIFO pointers, software registers and FSM datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            baud_reg     <= DEFAULT_DIV;
            tx_en_reg    <= 1'b1;
            irq_en_reg   <= 1'b0;
            state_reg    <= ST_IDLE;
            div_reg      <= 16'd1;
            clk_cnt_reg  <= 16'd0;
            bit_cnt_reg  <= 3'd0;
            sh_reg       <= 8'd0;
            txd_reg      <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (wr_txdata & fifo_full & ~pop) begin
                overflow_reg <= 1'b1;
            end else if (wr_status & io_data_write[3]) begin
                overflow_reg <= 1'b0;
            end
            if (wr_baud) begin
                baud_reg <= io_data_write[15:0];
            end
            if (wr_ctrl) begin
                tx_en_reg  <= io_data_write[0];
                irq_en_reg <= io_data_write[1];
            end
            state_reg   <= state_next;
            div_reg     <= div_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            sh_reg      <= sh_next;
            txd_reg     <= txd_next;
        end
    end

    // Next-state logic: bit timing, shifting and FIFO pops (including back-to-back frames).
    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        sh_next      = sh_reg;
        pop          = tx_en_reg & ~fifo_empty &
                       ((state_reg == ST_IDLE) | ((state_reg == ST_STOP) & bit_done));
        if (pop) begin
            // Divisor is sampled once per frame so mid-frame BAUDDIV writes wait.
            state_next   = ST_START;
            div_next     = eff_div;
            clk_cnt_next = eff_div - 16'd1;
            bit_cnt_next = 3'd0;
            sh_next      = mem[rd_ptr_reg];
        end else begin
            case (state_reg)
                ST_START: begin
                    if (bit_done) begin
                        state_next   = ST_DATA;
                        clk_cnt_next = div_reg - 16'd1;
                    end else begin
                        clk_cnt_next = clk_cnt_reg - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        clk_cnt_next = div_reg - 16'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_next = ST_STOP;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 3'd1;
                            sh_next      = {1'b0, sh_reg[7:1]};
                        end
                    end else begin
                        clk_cnt_next = clk_cnt_reg - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        state_next = ST_IDLE;
                    end else begin
                        clk_cnt_next = clk_cnt_reg - 16'd1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output logic: registered line level, read mux and drained interrupt.
    always_comb begin
        case (state_next)
            ST_START: txd_next = 1'b0;
            ST_DATA:  txd_next = sh_next[0];
            default:  txd_next = 1'b1;
        endcase
        io_data_read = 32'h0;
        if (win_hit) begin
            case (io_addr[3:2])
                2'd0:    io_data_read = {24'h0, count8};
                2'd1:    io_data_read = {16'h0, count8, 4'h0, overflow_reg, fifo_empty,
                                         fifo_full, (state_reg != ST_IDLE)};
                2'd2:    io_data_read = {16'h0, baud_reg};
                default: io_data_read = {30'h0, irq_en_reg, tx_en_reg};
            endcase
        end
        irq = irq_en_reg & fifo_empty & (state_reg == ST_IDLE);
    end

    assign uart_txd = txd_reg;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: register-map vector table plus directed frame sequences for io_uart_tx.
module tb_io_uart_tx;

    logic        clk_tb = 1'b0;
    logic        reset;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;
    logic        uart_txd;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic        en;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    always #5 clk_tb = ~clk_tb;

    io_uart_tx #(
        .BASE_ADDR   (8'h40),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd868)
    ) dut (
        .clk           (clk_tb),
        .reset         (reset),
        .io_addr       (io_addr),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .uart_txd      (uart_txd),
        .irq           (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic en);
        @(negedge clk_tb);
        io_addr       = a;
        io_data_write = d;
        io_en         = en;
        io_we         = 1'b1;
        @(posedge clk_tb);
        #1;
        io_en = 1'b0;
        io_we = 1'b0;
        $display("write addr=0x%02h data=0x%08h en=%0b", a, d, en);
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input logic [31:0] exp);
        io_addr = a;
        #1;
        check(name, io_data_read, exp);
    endtask

    // Walks one frame cycle by cycle; optionally performs one bus write at cycle wr_k.
    task automatic check_frame(input logic [7:0] b, input int div, input int exp_cnt,
                               input int wr_k, input logic [7:0] wa, input logic [31:0] wd);
        int   bi;
        logic exp_txd;
        for (int k = 1; k <= 10 * div; k++) begin
            @(posedge clk_tb);
            #1;
            io_en   = 1'b0;
            io_we   = 1'b0;
            io_addr = 8'h44;
            #1;
            bi = (k - 1) / div;
            if (bi == 0)      exp_txd = 1'b0;
            else if (bi == 9) exp_txd = 1'b1;
            else              exp_txd = b[bi-1];
            check($sformatf("txd byte%02h k%0d", b, k), {31'b0, uart_txd}, {31'b0, exp_txd});
            check($sformatf("busy byte%02h k%0d", b, k), {31'b0, io_data_read[0]}, 32'd1);
            if (k == 1) begin
                check($sformatf("count byte%02h", b), {24'b0, io_data_read[15:8]}, exp_cnt);
                check($sformatf("empty byte%02h", b), {31'b0, io_data_read[2]},
                      {31'b0, (exp_cnt == 0)});
            end
            if (k == wr_k) begin
                io_addr       = wa;
                io_data_write = wd;
                io_en         = 1'b1;
                io_we         = 1'b1;
            end
        end
        $display("frame byte=0x%02h div=%0d", b, div);
    endtask

    task automatic idle_check(input string name, input logic [31:0] exp_status, input logic exp_irq);
        @(posedge clk_tb);
        #1;
        io_addr = 8'h44;
        #1;
        check({name, " status"}, io_data_read, exp_status);
        check({name, " txd"}, {31'b0, uart_txd}, 32'd1);
        check({name, " irq"}, {31'b0, irq}, {31'b0, exp_irq});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        io_addr       = 8'h00;
        io_en         = 1'b0;
        io_we         = 1'b0;
        io_data_write = 32'h0;

        // Register-map vectors: {addr, write, io_en, wdata, expected read at addr}
        vecs[0]  = '{8'h40, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[1]  = '{8'h44, 1'b0, 1'b0, 32'h0,         32'h4};
        vecs[2]  = '{8'h48, 1'b0, 1'b0, 32'h0,         32'd868};
        vecs[3]  = '{8'h4C, 1'b0, 1'b0, 32'h0,         32'h1};
        vecs[4]  = '{8'h50, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[6]  = '{8'h48, 1'b1, 1'b1, 32'hFFFF_1234, 32'h1234};
        vecs[7]  = '{8'h48, 1'b1, 1'b0, 32'h5,         32'h1234};
        vecs[8]  = '{8'h4C, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h2};
        vecs[9]  = '{8'h44, 1'b0, 1'b0, 32'h0,         32'h4};
        vecs[10] = '{8'h40, 1'b1, 1'b0, 32'h77,        32'h0};
        vecs[11] = '{8'h4C, 1'b1, 1'b1, 32'h3,         32'h3};
        vecs[12] = '{8'h58, 1'b1, 1'b1, 32'h7,         32'h0};
        vecs[13] = '{8'h48, 1'b0, 1'b0, 32'h0,         32'h1234};
        vecs[14] = '{8'h44, 1'b1, 1'b1, 32'h7,         32'h4};
        vecs[15] = '{8'h48, 1'b1, 1'b1, 32'h4,         32'h4};

        // Reset state
        repeat (3) @(posedge clk_tb);
        #1;
        check("reset txd", {31'b0, uart_txd}, 32'd1);
        check("reset irq", {31'b0, irq}, 32'd0);
        read_check("reset status", 8'h44, 32'h4);
        read_check("reset bauddiv", 8'h48, 32'd868);
        read_check("reset ctrl", 8'h4C, 32'h1);
        @(negedge clk_tb);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wd, vecs[i].en);
            read_check($sformatf("vec%0d addr%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
        end
        check("irq idle empty", {31'b0, irq}, 32'd1);

        // Single byte at DIV=4
        bus_write(8'h40, 32'h55, 1'b1);
        check_frame(8'h55, 4, 0, 0, 8'h00, 32'h0);
        idle_check("single done", 32'h4, 1'b1);

        // Overflow with tx disabled, then drain
        bus_write(8'h48, 32'd2, 1'b1);
        bus_write(8'h4C, 32'h0, 1'b1);
        for (int i = 1; i <= 9; i++) bus_write(8'h40, i, 1'b1);
        read_check("ovf status", 8'h44, 32'h0000_080A);
        read_check("ovf txdata count", 8'h40, 32'h8);
        bus_write(8'h4C, 32'h1, 1'b1);
        for (int i = 1; i <= 8; i++) check_frame(8'(i), 2, 8 - i, 0, 8'h00, 32'h0);
        idle_check("ovf drained", 32'h0000_000C, 1'b0);
        bus_write(8'h44, 32'h8, 1'b1);
        read_check("ovf cleared", 8'h44, 32'h4);

        // Back-to-back frames
        bus_write(8'h4C, 32'h0, 1'b1);
        bus_write(8'h40, 32'hA5, 1'b1);
        bus_write(8'h40, 32'h0F, 1'b1);
        bus_write(8'h4C, 32'h1, 1'b1);
        check_frame(8'hA5, 2, 1, 0, 8'h00, 32'h0);
        check_frame(8'h0F, 2, 0, 0, 8'h00, 32'h0);
        idle_check("b2b done", 32'h4, 1'b0);

        // DIV=0 runs as DIV=1
        bus_write(8'h48, 32'h0, 1'b1);
        read_check("div0 readback", 8'h48, 32'h0);
        bus_write(8'h40, 32'h3C, 1'b1);
        check_frame(8'h3C, 1, 0, 0, 8'h00, 32'h0);
        idle_check("div0 done", 32'h4, 1'b0);

        // BAUDDIV write mid-frame applies to the next frame
        bus_write(8'h48, 32'd2, 1'b1);
        bus_write(8'h4C, 32'h0, 1'b1);
        bus_write(8'h40, 32'hC3, 1'b1);
        bus_write(8'h40, 32'h81, 1'b1);
        bus_write(8'h4C, 32'h1, 1'b1);
        check_frame(8'hC3, 2, 1, 5, 8'h48, 32'd8);
        check_frame(8'h81, 8, 0, 0, 8'h00, 32'h0);
        idle_check("baud change done", 32'h4, 1'b0);

        // Clearing tx_en mid-frame finishes the frame and keeps the FIFO
        bus_write(8'h4C, 32'h0, 1'b1);
        bus_write(8'h48, 32'd3, 1'b1);
        bus_write(8'h40, 32'h11, 1'b1);
        bus_write(8'h40, 32'h22, 1'b1);
        bus_write(8'h4C, 32'h1, 1'b1);
        check_frame(8'h11, 3, 1, 4, 8'h4C, 32'h0);
        idle_check("txen off", 32'h0000_0100, 1'b0);
        repeat (5) @(posedge clk_tb);
        idle_check("txen off hold", 32'h0000_0100, 1'b0);

        // Reset in the middle of DATA (byte 0x22, bit2 = 0)
        bus_write(8'h40, 32'h33, 1'b1);
        bus_write(8'h4C, 32'h1, 1'b1);
        repeat (10) @(posedge clk_tb);
        #1;
        check("pre-reset txd", {31'b0, uart_txd}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst txd", {31'b0, uart_txd}, 32'd1);
        check("midrst irq", {31'b0, irq}, 32'd0);
        read_check("midrst status", 8'h44, 32'h4);
        read_check("midrst bauddiv", 8'h48, 32'd868);
        read_check("midrst ctrl", 8'h4C, 32'h1);
        @(negedge clk_tb);
        reset = 1'b0;
        idle_check("post reset", 32'h4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
Name: io_uart_tx

Overview:
Memory-mapped UART transmitter on the core's IO bus, downstream of the mmu IO port. It consumes io_addr/io_en/io_we/io_data_write and returns io_data_read combinationally. Bytes written by software are buffered in a FIFO and serialized 8N1 on uart_txd. An irq output signals "transmit drained" for firmware polling or interrupts.

Parameters:
BASE_ADDR, 8'h40, byte address of the register window; must be 16-byte aligned; the window is 4 words.
FIFO_DEPTH, 8, FIFO entries; must be a power of 2, from 2 to 128.
DEFAULT_DIV, 16'd868, reset value of BAUDDIV in clocks per bit.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
io_addr  input  8  IO byte address; io_addr[3:2] selects the register when io_addr[7:4]==BASE_ADDR[7:4].
io_en  input  1  IO access strobe.
io_we  input  1  write qualifier, valid only with io_en.
io_data_write  input  32  write data.
io_data_read  output  32  combinational read data for the current io_addr.
uart_txd  output  1  serial output; idles high.
irq  output  1  level: CTRL.irq_en & fifo_empty & state==IDLE.

Behaviour:
- Write = io_en & io_we & window hit. Reads are combinational from io_addr, have no side effects, and do not need io_en. Unmapped addresses read 32'h0.
- Register map (word offset):
  0x0 TXDATA. Write pushes io_data_write[7:0]. Read returns {24'h0, count}.
  0x4 STATUS (read): bit0 busy (state!=IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[15:8] count. Writing 1 to bit3 clears overflow; other bits are read-only.
  0x8 BAUDDIV, r/w [15:0]; upper bits read 0. A value of 0 is treated as 1.
  0xC CTRL, r/w: bit0 tx_en, bit1 irq_en.
- Reset values: FIFO empty, count=0, overflow=0, BAUDDIV=DEFAULT_DIV, CTRL=2'b01, state=IDLE, uart_txd=1, irq=0.
- Async reset mid-frame: uart_txd returns to 1 immediately and the FIFO contents are discarded.
- FIFO push:
  - Not full: the byte is stored at the write edge and count increments.
  - Full: the byte is dropped and overflow is set.
  - Full with a pop at the same edge: the push is accepted and count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo depth. count has one extra bit, so full is count==FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if tx_en & !empty, pop the head into the shift register at this edge, latch BAUDDIV into the bit divisor, load the bit counter, and go to START.
  - A byte written at edge N into an empty FIFO pops at edge N+1. uart_txd falls at edge N+1.
  - START: txd=0 for DIV clocks, then DATA.
  - DATA: 8 bits LSB first, each held DIV clocks, then STOP.
  - STOP: txd=1 for DIV clocks. On the last stop clock, if tx_en & !empty, pop and go directly to START (back-to-back, no gap); otherwise go to IDLE.
  - Frame length is exactly 10*DIV clocks.
- uart_txd is registered: 1 in IDLE and STOP, 0 in START, data bit in DATA.
- A BAUDDIV write mid-frame takes effect at the next frame start.
- Clearing tx_en mid-frame completes the current frame; no new pop occurs.
- Simultaneous TXDATA write and FSM pop on an empty FIFO: no bypass; the byte pops on the following cycle.

Test Plan:
- Reset: assert reset mid-run -> uart_txd=1, STATUS=32'h0000_0004, BAUDDIV reads 868, CTRL reads 1, irq=0.
- Single byte: BAUDDIV=4, write TXDATA=0x55 at edge N -> txd low from N+1 for 4 clks, then bits 1,0,1,0,1,0,1,0 for 4 clks each, high 4 clks. busy=1 for exactly 40 clks, then idle; irq=1 when irq_en=1.
- Overflow: tx_en=0, 9 writes 0x01..0x09 (depth 8) -> STATUS count=8, full=1, overflow=1. Set tx_en -> bytes 0x01..0x08 sent, 0x09 never sent. Write STATUS 0x8 -> overflow=0.
- Back-to-back: DIV=2, write 0xA5 then 0x0F -> two 20-clk frames with no idle cycle between; empty=1 after the second pop.
- Divisor/enable: DIV=0 behaves as DIV=1 (10-clk frame). Write BAUDDIV=8 mid-frame -> current frame unchanged, next frame 80 clks. Clearing tx_en mid-frame finishes the frame and leaves the FIFO intact.
- Decode: read io_addr=BASE_ADDR+0x10 and 0x00 -> 32'h0. A write with io_en=0 has no effect. Reset mid-DATA -> txd=1 immediately, count=0.
